// File: rtl/instruction_pkg.sv
// instruction_pkg: pipeline stage encoding and default instruction ID width
package instruction_pkg;
  typedef enum logic [1:0] {STG_I, STG_X, STG_M, STG_R} stage_e;
  localparam int ID_W_DEF = 32;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: fetch handshake, hazard operands, redirect/stall inputs, stage status and kill report
interface pipe_ctrl_if #(parameter int ID_W = instruction_pkg::ID_W_DEF);
  logic fetch_v, fetch_ready;
  logic [4:0] i_rs1, i_rs2, x_rd, m_rd;
  logic i_rs1_use, i_rs2_use, x_rdv, x_load, m_rdv, pcv, mem_busy;
  logic inst_v_i, inst_v_x, inst_v_m, inst_v_r, kill_v;
  logic [ID_W-1:0] ci, cx, cm, cr, kill_id;
  modport master (
    output fetch_v, i_rs1, i_rs2, i_rs1_use, i_rs2_use, x_rd, x_rdv, x_load, m_rd, m_rdv, pcv, mem_busy,
    input fetch_ready, inst_v_i, inst_v_x, inst_v_m, inst_v_r, ci, cx, cm, cr, kill_v, kill_id
  );
  modport slave (
    input fetch_v, i_rs1, i_rs2, i_rs1_use, i_rs2_use, x_rd, x_rdv, x_load, m_rd, m_rdv, pcv, mem_busy,
    output fetch_ready, inst_v_i, inst_v_x, inst_v_m, inst_v_r, ci, cx, cm, cr, kill_v, kill_id
  );
endinterface

// File: rtl/pipe_hazard.sv
// pipe_hazard: does a valid nonzero destination feed either enabled I-stage source
module pipe_hazard (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_use,
  input  logic       rs2_use,
  input  logic [4:0] rd,
  input  logic       rdv,
  output logic       hit
);
  assign hit = rdv & (rd != 5'd0) & ((rs1_use & (rs1 == rd)) | (rs2_use & (rs2 == rd)));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: I/X/M/R valid+ID tracking with stall, bubble and squash; PIPE_CTRL_FORWARD_EN limits hazards to load-use
module pipe_ctrl import instruction_pkg::*; #(
  parameter int ID_W = ID_W_DEF
) (
  input logic clk,
  input logic reset,
  pipe_ctrl_if.slave p
);
  logic x_q, x_hit, hazard, squash, accept;
  logic [ID_W-1:0] next_id;
  pipe_hazard u_hx (
    .rs1(p.i_rs1), .rs2(p.i_rs2), .rs1_use(p.i_rs1_use), .rs2_use(p.i_rs2_use),
    .rd(p.x_rd), .rdv(x_q), .hit(x_hit)
  );
`ifdef PIPE_CTRL_FORWARD_EN
  assign x_q = p.inst_v_x & p.x_load;
  assign hazard = p.inst_v_i & x_hit;
`else
  logic m_hit;
  pipe_hazard u_hm (
    .rs1(p.i_rs1), .rs2(p.i_rs2), .rs1_use(p.i_rs1_use), .rs2_use(p.i_rs2_use),
    .rd(p.m_rd), .rdv(p.inst_v_m & p.m_rdv), .hit(m_hit)
  );
  assign x_q = p.inst_v_x & p.x_rdv;
  assign hazard = p.inst_v_i & (x_hit | m_hit);
`endif
  assign squash = p.pcv & !p.mem_busy;
  assign p.fetch_ready = reset & !p.mem_busy & !hazard & !p.pcv;
  assign accept = p.fetch_v & p.fetch_ready;
  // stage advance: M stall freezes everything, then redirect beats hazard, else I moves to X
  always_ff @(posedge clk) begin
    if (!reset) begin
      p.inst_v_i <= 1'b0;
      p.inst_v_x <= 1'b0;
      p.inst_v_m <= 1'b0;
      p.inst_v_r <= 1'b0;
      p.kill_v <= 1'b0;
      p.ci <= '0;
      p.cx <= '0;
      p.cm <= '0;
      p.cr <= '0;
      p.kill_id <= '0;
      next_id <= '0;
    end else begin
      p.inst_v_r <= p.inst_v_m & !p.mem_busy;
      p.cr <= p.cm;
      p.kill_v <= squash & p.inst_v_i;
      if (squash & p.inst_v_i) p.kill_id <= p.ci;
      if (!p.mem_busy) begin
        p.inst_v_m <= p.inst_v_x;
        p.cm <= p.cx;
        if (p.pcv) begin
          p.inst_v_x <= 1'b0;
          p.inst_v_i <= 1'b0;
        end else if (hazard) begin
          p.inst_v_x <= 1'b0;
        end else begin
          p.inst_v_x <= p.inst_v_i;
          p.cx <= p.ci;
          p.inst_v_i <= accept;
          if (accept) begin
            p.ci <= next_id;
            next_id <= next_id + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural pipeline model
module tb_pipe_ctrl;
  localparam int W = 5;
`ifdef PIPE_CTRL_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int c0;
  bit last_fr;
  bit mv[4];
  logic [W-1:0] mid[4];
  logic [W-1:0] m_next = '0;
  bit mk_v;
  logic [W-1:0] mk_id;
  logic [W-1:0] sb[$];
  logic [W-1:0] ret_id[$];
  int ret_cyc[$];
  int exp_ret[4] = '{0, 1, 2, 3};

  pipe_ctrl_if #(.ID_W(W)) bus();
  pipe_ctrl #(.ID_W(W)) dut (.clk(clk), .reset(reset), .p(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit rs_hit(input logic [4:0] rd);
    return rd != 5'd0 && ((bus.i_rs1_use && bus.i_rs1 == rd) || (bus.i_rs2_use && bus.i_rs2 == rd));
  endfunction

  function automatic bit m_hazard();
    if (FWD) return mv[0] && mv[1] && bus.x_load && rs_hit(bus.x_rd);
    return mv[0] && ((mv[1] && bus.x_rdv && rs_hit(bus.x_rd)) || (mv[2] && bus.m_rdv && rs_hit(bus.m_rd)));
  endfunction

  task automatic quiet();
    bus.fetch_v = 0; bus.i_rs1 = 0; bus.i_rs2 = 0; bus.i_rs1_use = 0; bus.i_rs2_use = 0;
    bus.x_rd = 0; bus.x_rdv = 0; bus.x_load = 0; bus.m_rd = 0; bus.m_rdv = 0;
    bus.pcv = 0; bus.mem_busy = 0;
  endtask

  // one clock: check the combinational handshake, advance the model, then compare all stages
  task automatic step();
    bit haz, rdy, acc;
    bit nv[4];
    logic [W-1:0] nid[4];
    #1;
    haz = m_hazard();
    rdy = reset && !bus.mem_busy && !haz && !bus.pcv;
    acc = bus.fetch_v && rdy;
    last_fr = bus.fetch_ready;
    chk("fetch_ready", bus.fetch_ready, rdy);
    @(posedge clk);
    cyc++;
    if (!reset) begin
      mv = '{0, 0, 0, 0};
      mid = '{0, 0, 0, 0};
      m_next = '0;
      mk_v = 0;
      sb.delete();
    end else begin
      nv = mv;
      nid = mid;
      nv[3] = mv[2] && !bus.mem_busy;
      nid[3] = mid[2];
      mk_v = 0;
      if (!bus.mem_busy) begin
        nv[2] = mv[1];
        nid[2] = mid[1];
        if (bus.pcv) begin
          nv[1] = 0;
          nv[0] = 0;
          if (mv[0]) begin
            mk_v = 1;
            mk_id = mid[0];
            if (sb.size() > 0) void'(sb.pop_back());
          end
        end else if (haz) begin
          nv[1] = 0;
        end else begin
          nv[1] = mv[0];
          nid[1] = mid[0];
          nv[0] = acc;
          if (acc) begin
            nid[0] = m_next;
            sb.push_back(m_next);
            m_next++;
          end
        end
      end
      mv = nv;
      mid = nid;
    end
    @(negedge clk);
    chk("inst_v_i", bus.inst_v_i, mv[0]);
    chk("inst_v_x", bus.inst_v_x, mv[1]);
    chk("inst_v_m", bus.inst_v_m, mv[2]);
    chk("inst_v_r", bus.inst_v_r, mv[3]);
    if (mv[0]) chk("ci", bus.ci, mid[0]);
    if (mv[1]) chk("cx", bus.cx, mid[1]);
    if (mv[2]) chk("cm", bus.cm, mid[2]);
    if (mv[3]) chk("cr", bus.cr, mid[3]);
    chk("kill_v", bus.kill_v, mk_v);
    if (mk_v) chk("kill_id", bus.kill_id, mk_id);
    if (bus.inst_v_r) begin
      ret_id.push_back(bus.cr);
      ret_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL retire_order: got retire of %0d expected none (cycle %0d)", bus.cr, cyc);
      end else chk("retire_order", bus.cr, sb.pop_front());
    end
  endtask

  initial begin
    quiet();
    @(negedge clk);
    bus.fetch_v = 1;
    step();
    chk("rst_fetch_ready", last_fr, 0);
    step();
    chk("rst_v_i", bus.inst_v_i, 0);
    chk("rst_v_r", bus.inst_v_r, 0);
    chk("rst_kill_v", bus.kill_v, 0);
    chk("rst_ci", bus.ci, 0);
    reset = 1;
    quiet();
    ret_id.delete();
    ret_cyc.delete();
    c0 = cyc;
    bus.fetch_v = 1;
    repeat (4) step();
    bus.fetch_v = 0;
    repeat (4) step();
    chk("sl_count", ret_id.size(), 4);
    if (ret_cyc.size() > 0) chk("sl_first_retire_cycle", ret_cyc[0] - c0, 4);
    for (int i = 0; i < 4; i++)
      if (i < ret_id.size()) begin
        chk("sl_id", ret_id[i], exp_ret[i]);
        chk("sl_consecutive", ret_cyc[i] - c0, 4 + i);
      end
    bus.fetch_v = 1;
    step();
    step();
    bus.x_rd = 5; bus.x_rdv = 1; bus.x_load = 1; bus.i_rs1 = 5; bus.i_rs1_use = 1;
    step();
    chk("lu_fetch_ready", last_fr, 0);
    chk("lu_bubble", bus.inst_v_x, 0);
    chk("lu_v_i", bus.inst_v_i, 1);
    chk("lu_ci_held", bus.ci, 5);
    quiet();
    bus.fetch_v = 1;
    step();
    chk("lu_resume", last_fr, 1);
    chk("lu_cx", bus.cx, 5);
    step();
    chk("rd_ci", bus.ci, 7);
    bus.pcv = 1;
    step();
    chk("rd_fetch_ready", last_fr, 0);
    chk("rd_kill_v", bus.kill_v, 1);
    chk("rd_kill_id", bus.kill_id, 7);
    chk("rd_v_i", bus.inst_v_i, 0);
    bus.pcv = 0;
    step();
    chk("rd_next_id", bus.ci, 8);
    chk("rd_kill_clear", bus.kill_v, 0);
    step();
    step();
    bus.mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      bus.pcv = (i == 1);
      step();
      chk("st_fetch_ready", last_fr, 0);
      chk("st_v_r", bus.inst_v_r, 0);
      chk("st_v_i", bus.inst_v_i, 1);
      chk("st_v_m", bus.inst_v_m, 1);
      chk("st_ci", bus.ci, 10);
      chk("st_cx", bus.cx, 9);
      chk("st_cm", bus.cm, 8);
      chk("st_kill_v", bus.kill_v, 0);
    end
    bus.mem_busy = 0;
    bus.pcv = 0;
    step();
    chk("st_release_v_r", bus.inst_v_r, 1);
    chk("st_release_cr", bus.cr, 8);
    chk("st_release_ci", bus.ci, 11);
    bus.x_rd = 0; bus.x_rdv = 1; bus.x_load = 1; bus.i_rs1 = 0; bus.i_rs1_use = 1;
    step();
    chk("x0_fetch_ready", last_fr, 1);
    quiet();
    bus.fetch_v = 1;
    bus.m_rd = 3; bus.m_rdv = 1; bus.i_rs1 = 3; bus.i_rs1_use = 1;
    step();
    chk("m_raw_fetch_ready", last_fr, FWD);
    chk("m_raw_v_x", bus.inst_v_x, FWD);
    quiet();
    bus.fetch_v = 1;
    for (int i = 0; i < 64 && m_next != '1; i++) step();
    step();
    chk("wrap_hi", bus.ci, 31);
    step();
    chk("wrap_lo", bus.ci, 0);
    reset = 0;
    bus.pcv = 1;
    step();
    chk("mid_rst_v_i", bus.inst_v_i, 0);
    chk("mid_rst_v_x", bus.inst_v_x, 0);
    chk("mid_rst_v_m", bus.inst_v_m, 0);
    chk("mid_rst_kill_v", bus.kill_v, 0);
    reset = 1;
    bus.pcv = 0;
    step();
    chk("post_rst_v_i", bus.inst_v_i, 1);
    chk("post_rst_id", bus.ci, 0);
    for (int n = 0; n < 3000; n++) begin
      bus.fetch_v = $urandom_range(0, 3) != 0;
      bus.i_rs1 = 5'($urandom_range(0, 3));
      bus.i_rs2 = 5'($urandom_range(0, 3));
      bus.i_rs1_use = 1'($urandom_range(0, 1));
      bus.i_rs2_use = 1'($urandom_range(0, 1));
      bus.x_rd = 5'($urandom_range(0, 3));
      bus.x_rdv = 1'($urandom_range(0, 1));
      bus.x_load = 1'($urandom_range(0, 1));
      bus.m_rd = 5'($urandom_range(0, 3));
      bus.m_rdv = 1'($urandom_range(0, 1));
      bus.pcv = $urandom_range(0, 7) == 0;
      bus.mem_busy = $urandom_range(0, 3) == 0;
      reset = $urandom_range(0, 199) != 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter ID_W, default 32, width of instruction sequence IDs.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports fetch_v input 1 (fetched instruction offered) and fetch_ready output 1 (accepted into I this cycle).
REQ-005 SHALL have ports i_rs1, i_rs2 input 5 each and i_rs1_use, i_rs2_use input 1 each; these are the I-stage source registers and their read enables.
REQ-006 SHALL have ports x_rd input 5, x_rdv input 1 and x_load input 1, describing the X-stage destination.
REQ-007 SHALL have ports m_rd input 5 and m_rdv input 1, describing the M-stage destination.
REQ-008 SHALL have port pcv  input  1  X-stage redirect (taken branch or jump).
REQ-009 SHALL have port mem_busy  input  1  M stage cannot complete.
REQ-010 SHALL have ports inst_v_i, inst_v_x, inst_v_m, inst_v_r output 1 each; these are the per-stage valid bits.
REQ-011 SHALL have ports ci, cx, cm, cr output ID_W each; these are the per-stage sequence IDs.
REQ-012 SHALL have ports kill_v output 1 and kill_id output ID_W, reporting a squashed I-stage instruction.

Function
REQ-013 SHALL define an accept as fetch_v & fetch_ready, where fetch_ready = !mem_busy & !hazard & !pcv.
REQ-014 SHALL assign each accepted instruction ci = next_id, then increment next_id modulo 2^ID_W (0xFFFFFFFF wraps to 0).
REQ-015 SHALL NOT reuse squashed IDs.
REQ-016 SHALL load the R stage every cycle as inst_v_r <= inst_v_m & !mem_busy, cr <= cm, so that R is valid for exactly one cycle per retire.
REQ-017 SHALL hold inst_v_i/x/m and ci/cx/cm while mem_busy=1, and ignore pcv and hazard in that case.
REQ-018 SHALL advance the M stage when mem_busy=0: inst_v_m <= inst_v_x, cm <= cx.
REQ-019 SHALL squash on pcv=1 & mem_busy=0: inst_v_x <= 0, inst_v_i <= 0, and the fetch that cycle is refused; pcv takes priority over hazard.
REQ-020 SHALL bubble on hazard=1 & pcv=0 & mem_busy=0: inst_v_x <= 0 while inst_v_i and ci hold.
REQ-021 SHALL move I to X otherwise: inst_v_x <= inst_v_i, cx <= ci, inst_v_i <= accept, ci <= next_id if accept.
REQ-022 SHALL, on a squash with inst_v_i=1, raise kill_v=1 with kill_id=ci on the next cycle for one cycle; kill_v SHALL be 0 otherwise.
REQ-023 SHALL qualify every hazard match with: stage valid, matching rd nonzero, and the source's use bit set; x0 never causes a hazard.
REQ-024 SHALL qualify x_rdv and m_rdv internally with inst_v_x and inst_v_m.

Reset
REQ-025 SHALL, while reset=0 at a clock edge, clear all valids, kill_v, next_id and all IDs to 0; fetch_ready SHALL be 0 during reset.
REQ-026 SHALL, on reset mid-operation, discard in-flight instructions without kill_v.
REQ-027 SHALL issue the first post-reset accept with ID 0.

Configuration
REQ-028 SHALL use macro PIPE_CTRL_FORWARD_EN; when defined, hazard = inst_v_i & inst_v_x & x_load & rs-match(x_rd), i.e. the load-use case only.
REQ-029 SHALL, when PIPE_CTRL_FORWARD_EN is undefined, compute hazard = inst_v_i & (rs-match(x_rd) with x_rdv | rs-match(m_rd) with m_rdv), i.e. all RAW against X and M.

Structure
REQ-030 SHALL place the stage enum (I, X, M, R) and the ID_W default constant in instruction_pkg.
REQ-031 SHALL implement the rs-match comparison as sub-module pipe_hazard (combinational); the stage registers SHALL stay in pipe_ctrl.

Verification
REQ-032 Straight-line: fetch_v=1 for 4 cycles -> IDs 0..3 appear in cr on consecutive cycles, 4 cycles after the first accept.
REQ-033 Load-use: X holds a load with x_rd=5 while I has i_rs1=5 and use=1 -> one X bubble, ci held, fetch_ready=0 for 1 cycle.
REQ-034 Redirect: pcv=1 with I holding ID 7 -> kill_v=1 and kill_id=7 next cycle, and the next accept gets ID 8.
REQ-035 mem_busy=1 for 3 cycles -> inst_v_r=0 and all stages frozen; pcv asserted during the stall is ignored.
REQ-036 x0 and wrap-around: x_rd=0 with i_rs1=0 -> no stall; with next_id=0xFFFFFFFF, two accepts -> IDs 0xFFFFFFFF then 0x0.
REQ-037 With PIPE_CTRL_FORWARD_EN undefined: an ALU op in M with m_rd=3 and I reading x3 -> 1 bubble; with the macro defined -> 0 bubbles.
